// File: rtl/ddr3_tg_pkg.sv
// Shared definitions for the DDR3 traffic generator: controller command codes,
// FSM state encoding and the LFSR feedback taps.
package ddr3_tg_pkg;

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_SCR = 3'd1;
  localparam logic [2:0] CMD_SCW = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_FINISH
  } tg_state_e;

  // Taps 16,14,13,11 expressed as a mask over bits [15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/ddr3_traffic_gen_if.sv
// Host-side bus between the traffic generator (master) and ddr3_controller (slave).
interface ddr3_traffic_gen_if #(
  parameter int DW = 16,
  parameter int AW = 25
);
  logic          initddr;
  logic [2:0]    cmd;
  logic [1:0]    sz;
  logic [2:0]    op;
  logic [DW-1:0] din;
  logic [AW-1:0] addr;
  logic          read;
  logic [DW-1:0] dout;
  logic [AW-1:0] raddr;
  logic          validout;
  logic [5:0]    fillcount;
  logic          notfull;
  logic          ready;

  modport master (
    output initddr, cmd, sz, op, din, addr, read,
    input  dout, raddr, validout, fillcount, notfull, ready
  );

  modport slave (
    input  initddr, cmd, sz, op, din, addr, read,
    output dout, raddr, validout, fillcount, notfull, ready
  );
endinterface

// File: rtl/ddr3_tg_lfsr.sv
// 16-bit Fibonacci LFSR, left-shifting; load restarts from SEED (a zero seed becomes 1).
module ddr3_tg_lfsr
  import ddr3_tg_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        advance,
  output logic [15:0] value
);

  localparam logic [15:0] SEED_NZ = (SEED == 16'd0) ? 16'd1 : SEED;

  logic [15:0] r_value;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_value <= '0;
    end else if (load) begin
      r_value <= SEED_NZ;
    end else if (advance) begin
      r_value <= {r_value[14:0], ^(r_value & LFSR_TAPS)};
    end
  end

  assign value = r_value;

endmodule

// File: rtl/ddr3_traffic_gen.sv
// DDR3 bring-up engine: init, write NUM_WORDS LFSR words, read back and compare.
// Optional build macro DDR3_TRAFFIC_GEN_INJECT_EN adds error injection and write throttling.
module ddr3_traffic_gen
  import ddr3_tg_pkg::*;
#(
  parameter int          DW        = 16,
  parameter int          AW        = 25,
  parameter int          NUM_WORDS = 64,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned ADDR_STEP = 8,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          TIMEOUT   = 4095
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
`ifdef DDR3_TRAFFIC_GEN_INJECT_EN
  input  logic        inject,
`endif
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] err_count,
  ddr3_traffic_gen_if.master bus
);

  localparam logic [AW-1:0] BASE = AW'(BASE_ADDR);
  localparam logic [AW-1:0] STEP = AW'(ADDR_STEP);

  tg_state_e     r_state, w_next;
  logic [AW-1:0] r_cur_addr, r_exp_addr;
  logic [15:0]   r_issue_cnt, r_pop_cnt, r_tmo_cnt, r_err_cnt;
  logic          r_pass, r_timeout;
  logic [15:0]   w_wr_lfsr, w_rd_lfsr;
  logic          w_start_ok, w_issue, w_last_issue, w_pop, w_pop_valid;
  logic          w_mismatch, w_pops_done, w_tmo_hit, w_tmo_abort, w_flip, w_can_write;

  function automatic logic [DW-1:0] f_expand(input logic [15:0] v);
    logic [DW-1:0] w;
    for (int i = 0; i < DW; i++) w[i] = v[4'(i % 16)];
    return w;
  endfunction

`ifdef DDR3_TRAFFIC_GEN_INJECT_EN
  logic r_inject;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          r_inject <= 1'b0;
    else if (w_start_ok) r_inject <= inject;
  end
  assign w_flip      = r_inject && (r_issue_cnt == 16'(NUM_WORDS / 2));
  assign w_can_write = bus.notfull && (bus.fillcount < 6'd32);
`else
  logic w_unused;
  assign w_unused    = ^bus.fillcount;
  assign w_flip      = 1'b0;
  assign w_can_write = bus.notfull;
`endif

  assign w_start_ok   = (r_state == ST_IDLE) && start;
  assign w_issue      = ((r_state == ST_WRITE) && w_can_write) ||
                        ((r_state == ST_READ) && bus.notfull);
  assign w_last_issue = w_issue && (r_issue_cnt == 16'(NUM_WORDS - 1));
  assign w_pop        = ((r_state == ST_READ) || (r_state == ST_DRAIN)) && bus.validout;
  assign w_pop_valid  = w_pop && (r_pop_cnt < 16'(NUM_WORDS));
  assign w_mismatch   = w_pop_valid &&
                        ((bus.dout != f_expand(w_rd_lfsr)) || (bus.raddr != r_exp_addr));
  assign w_pops_done  = (r_pop_cnt == 16'(NUM_WORDS)) ||
                        (w_pop_valid && (r_pop_cnt == 16'(NUM_WORDS - 1)));
  assign w_tmo_hit    = (r_tmo_cnt == 16'(TIMEOUT));

  ddr3_tg_lfsr #(.SEED(SEED)) u_wr_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (w_start_ok),
    .advance (w_issue && (r_state == ST_WRITE)),
    .value   (w_wr_lfsr)
  );

  ddr3_tg_lfsr #(.SEED(SEED)) u_rd_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (w_start_ok),
    .advance (w_pop_valid),
    .value   (w_rd_lfsr)
  );

  always_comb begin
    w_next      = r_state;
    w_tmo_abort = 1'b0;
    bus.cmd     = CMD_NOP;
    bus.addr    = '0;
    bus.din     = '0;
    bus.initddr = 1'b0;
    unique case (r_state)
      ST_IDLE: if (start) w_next = bus.ready ? ST_WRITE : ST_INIT;
      ST_INIT: begin
        bus.initddr = !bus.ready;
        if (bus.ready) begin
          w_next = ST_WRITE;
        end else if (w_tmo_hit) begin
          w_next      = ST_FINISH;
          w_tmo_abort = 1'b1;
        end
      end
      ST_WRITE: begin
        if (w_issue) begin
          bus.cmd  = CMD_SCW;
          bus.addr = r_cur_addr;
          bus.din  = f_expand(w_wr_lfsr) ^ DW'(w_flip);
        end
        if (w_last_issue) w_next = ST_READ;
      end
      ST_READ: begin
        if (w_issue) begin
          bus.cmd  = CMD_SCR;
          bus.addr = r_cur_addr;
        end
        if (w_last_issue) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_pops_done) begin
          w_next = ST_FINISH;
        end else if (w_tmo_hit) begin
          w_next      = ST_FINISH;
          w_tmo_abort = 1'b1;
        end
      end
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cur_addr  <= '0;
      r_exp_addr  <= '0;
      r_issue_cnt <= '0;
      r_pop_cnt   <= '0;
      r_tmo_cnt   <= '0;
      r_err_cnt   <= '0;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state <= w_next;
      // Progress watchdog: any state change, issue or pop counts as progress
      if ((w_next != r_state) || w_issue || w_pop) r_tmo_cnt <= '0;
      else if (r_tmo_cnt != 16'hFFFF)              r_tmo_cnt <= r_tmo_cnt + 16'd1;
      if (w_start_ok) begin
        r_err_cnt   <= '0;
        r_pass      <= 1'b0;
        r_timeout   <= 1'b0;
        r_issue_cnt <= '0;
        r_pop_cnt   <= '0;
        r_cur_addr  <= BASE;
        r_exp_addr  <= BASE;
      end
      if (w_issue) begin
        r_issue_cnt <= w_last_issue ? 16'd0 : r_issue_cnt + 16'd1;
        r_cur_addr  <= w_last_issue ? BASE : r_cur_addr + STEP;
      end
      if (w_pop_valid) begin
        r_pop_cnt  <= r_pop_cnt + 16'd1;
        r_exp_addr <= r_exp_addr + STEP;
        if (w_mismatch && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
      end
      if (w_tmo_abort) r_timeout <= 1'b1;
      if (r_state == ST_FINISH) r_pass <= (r_err_cnt == 16'd0) && !r_timeout;
    end
  end

  assign bus.sz    = '0;
  assign bus.op    = '0;
  assign bus.read  = w_pop;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_FINISH);
  assign pass      = r_pass;
  assign timeout   = r_timeout;
  assign err_count = r_err_cnt;

endmodule

// File: tb/tb_ddr3_traffic_gen.sv
// Randomised bench for ddr3_traffic_gen: behavioural controller/memory model,
// expected command stream and per-run result scoreboard.
module tb_ddr3_traffic_gen;
  import ddr3_tg_pkg::*;

  localparam int          DW   = 16;
  localparam int          AW   = 25;
  localparam int          NW   = 64;
  localparam int          STEP = 8;
  localparam int          TMO  = 250;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
`ifdef DDR3_TRAFFIC_GEN_INJECT_EN
  logic        inject = 1'b0;
`endif
  logic        busy, done, pass, timeout;
  logic [15:0] err_count;

  ddr3_traffic_gen_if #(.DW(DW), .AW(AW)) bus ();

  ddr3_traffic_gen #(
    .DW(DW), .AW(AW), .NUM_WORDS(NW), .BASE_ADDR(0), .ADDR_STEP(STEP),
    .SEED(SEED), .TIMEOUT(TMO)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .start     (start),
`ifdef DDR3_TRAFFIC_GEN_INJECT_EN
    .inject    (inject),
`endif
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .timeout   (timeout),
    .err_count (err_count),
    .bus       (bus.master)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference LFSR: polynomial x^16+x^14+x^13+x^11+1, new bit enters at the bottom
  function automatic logic [15:0] ref_next(input logic [15:0] v);
    int   taps[4] = '{16, 14, 13, 11};
    logic fb = 1'b0;
    foreach (taps[i]) fb ^= v[taps[i] - 1];
    return {v[14:0], fb};
  endfunction

  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} cmd_t;
  typedef struct packed {logic [15:0] err; logic tmo; logic pss;} res_t;
  typedef struct {logic [AW-1:0] a; logic [DW-1:0] d; int due;} ret_t;

  cmd_t exp_w[$], exp_r[$];
  res_t sb[$];
  ret_t q[$];
  logic [DW-1:0] mem [logic [AW-1:0]];

  int cyc = 0, init_cnt = 0, rd_idx = 0, last_due = 0, done_cnt = 0, stall = 0;
  bit corrupt_d[NW], corrupt_a[NW];
  bit hold_ret = 0, force_nf = 0, model_flush = 0, pend_pass = 0, exp_pass = 0;

  // Controller model: accepts whatever the DUT presents ahead of the next edge
  always @(negedge clk) begin
    logic [DW-1:0] d;
    logic [AW-1:0] a2;
    cyc++;
    if (bus.initddr) init_cnt++;
    if (rst_n && bus.notfull && bus.cmd == CMD_SCW) mem[bus.addr] = bus.din;
    if (rst_n && bus.notfull && bus.cmd == CMD_SCR) begin
      d  = mem.exists(bus.addr) ? mem[bus.addr] : '0;
      a2 = bus.addr;
      if (rd_idx < NW && corrupt_d[rd_idx]) d ^= 16'h0100;
      if (rd_idx < NW && corrupt_a[rd_idx]) a2 = a2 + AW'(8);
      last_due = (cyc + int'($urandom_range(2, 12)) > last_due) ?
                 cyc + int'($urandom_range(2, 12)) : last_due;
      q.push_back('{a2, d, last_due});
      rd_idx++;
    end
    if (rst_n && bus.read && q.size() > 0) void'(q.pop_front());
  end

  always @(posedge clk) begin
    #1;
    if (model_flush) begin
      q.delete();
      model_flush = 0;
    end
    bus.ready     = (init_cnt >= 200);
    bus.notfull   = force_nf ? 1'b1 : (stall > 0) ? 1'b0 : ($urandom_range(0, 7) != 0);
    if (stall > 0) stall--;
    bus.fillcount = force_nf ? 6'd0 : 6'($urandom_range(0, 47));
    bus.validout  = !hold_ret && q.size() > 0 && q[0].due <= cyc;
    bus.dout      = (q.size() > 0) ? q[0].d : '0;
    bus.raddr     = (q.size() > 0) ? q[0].a : '0;
  end

  // Monitor: command stream, initddr level and end-of-run results
  always @(negedge clk) begin
    cmd_t c;
    res_t r;
    if (rst_n) begin
      if (pend_pass) begin
        chk("pass", 64'(pass), 64'(exp_pass));
        pend_pass = 0;
      end
      if (bus.cmd == CMD_SCW || bus.cmd == CMD_SCR) chk("issue_notfull", 64'(bus.notfull), 64'd1);
      if (bus.cmd == CMD_SCW) begin
        if (exp_w.size() == 0) chk("extra_scw", 64'd1, 64'd0);
        else begin
          c = exp_w.pop_front();
          chk("scw_addr", 64'(bus.addr), 64'(c.a));
          chk("scw_din", 64'(bus.din), 64'(c.d));
        end
      end
      if (bus.cmd == CMD_SCR) begin
        if (exp_r.size() == 0 || exp_w.size() != 0) chk("scr_order", 64'(exp_w.size()), 64'd0);
        else begin
          c = exp_r.pop_front();
          chk("scr_addr", 64'(bus.addr), 64'(c.a));
          chk("scr_din", 64'(bus.din), 64'd0);
        end
      end
      if (bus.initddr || (busy && !bus.ready))
        chk("initddr", 64'(bus.initddr), 64'(busy && !bus.ready));
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
        else begin
          r = sb.pop_front();
          chk("err_count", 64'(err_count), 64'(r.err));
          chk("timeout", 64'(timeout), 64'(r.tmo));
          chk("writes_all_issued", 64'(exp_w.size()), 64'd0);
          chk("reads_all_issued", 64'(exp_r.size()), 64'd0);
          exp_pass  = r.pss;
          pend_pass = 1;
        end
      end
    end
  end

  task automatic launch(input logic [15:0] e_err, input logic e_tmo, input logic inj);
    logic [15:0] v = SEED;
    exp_w.delete();
    exp_r.delete();
    for (int k = 0; k < NW; k++) begin
      exp_w.push_back('{AW'(k * STEP), v ^ DW'(inj && k == NW / 2)});
      exp_r.push_back('{AW'(k * STEP), DW'(0)});
      v = ref_next(v);
    end
    sb.push_back('{e_err, e_tmo, (e_err == 16'd0) && !e_tmo});
    rd_idx = 0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int seen = done_cnt;
    int i = 0;
    while (done_cnt == seen && i < 20000) begin
      @(negedge clk);
      i++;
    end
    if (done_cnt == seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_done: no done pulse within %0d cycles", name, i);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_faults();
    foreach (corrupt_d[i]) begin
      corrupt_d[i] = 0;
      corrupt_a[i] = 0;
    end
  endtask

  initial begin
    int saved;
    clear_faults();
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass), 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);
    chk("rst_cmd", 64'(bus.cmd), 64'(CMD_NOP));
    chk("rst_read", 64'(bus.read), 64'd0);

    // Cold start through INIT
    launch(16'd0, 1'b0, 1'b0);
    wait_done("init_run");

    // ready already high: first write the cycle after start
    force_nf = 1;
    @(negedge clk);
    launch(16'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("first_cmd", 64'(bus.cmd), 64'(CMD_SCW));
    chk("first_addr", 64'(bus.addr), 64'd0);
    chk("first_din", 64'(bus.din), 64'hACE1);
    force_nf = 0;
    wait_done("warm_run");

    // Ten-cycle back-pressure mid-write
    launch(16'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4000 && exp_w.size() > 32; i++) @(negedge clk);
    stall = 10;
    wait_done("stall_run");

    // Data corruption on words 3 and 40
    corrupt_d[3]  = 1;
    corrupt_d[40] = 1;
    launch(16'd2, 1'b0, 1'b0);
    wait_done("data_err_run");
    clear_faults();

    // Return address off by 8 on one word
    corrupt_a[17] = 1;
    launch(16'd1, 1'b0, 1'b0);
    wait_done("addr_err_run");
    clear_faults();

    // Returns never arrive: DRAIN watchdog
    hold_ret = 1;
    launch(16'd0, 1'b1, 1'b0);
    wait_done("timeout_run");
    hold_ret    = 0;
    model_flush = 1;
    @(negedge clk);

    // Asynchronous reset mid-READ, then a clean run
    launch(16'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4000 && (exp_w.size() != 0 || exp_r.size() > 40); i++) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    exp_w.delete();
    exp_r.delete();
    model_flush = 1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_cmd", 64'(bus.cmd), 64'(CMD_NOP));
    chk("abort_read", 64'(bus.read), 64'd0);
    chk("abort_err", 64'(err_count), 64'd0);
    saved = done_cnt;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt), 64'(saved));
    launch(16'd0, 1'b0, 1'b0);
    wait_done("post_reset_run");

`ifdef DDR3_TRAFFIC_GEN_INJECT_EN
    inject = 1'b1;
    launch(16'd1, 1'b0, 1'b1);
    inject = 1'b0;
    wait_done("inject_run");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
